// File: rtl/bht_pkg.sv
// Shared types for the branch history table controller: counter encoding,
// FSM states, update FIFO entry and the saturating counter step.
package bht_pkg;

   // Table index width; the controller's IDX_BITS defaults to this value.
   localparam int BHT_IDX_BITS = 6;

   typedef logic [1:0] ctr_t;

   localparam ctr_t STRONG_NT = 2'b00;
   localparam ctr_t WEAK_NT   = 2'b01;
   localparam ctr_t WEAK_T    = 2'b10;
   localparam ctr_t STRONG_T  = 2'b11;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   typedef struct packed {
      logic [BHT_IDX_BITS-1:0] idx;
      logic                    taken;
   } upd_entry_t;

   // Two-bit saturating step: counters hold at either end and never wrap.
   function automatic ctr_t sat_next(input ctr_t c, input logic taken);
      ctr_t n;
      case (c)
         STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
         WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
         default:   n = taken ? STRONG_T : WEAK_T;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Synchronous update FIFO: one push and one pop per cycle, flushed by reset.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module bht_upd_fifo
   import bht_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  upd_entry_t push_data,
   input  logic       pop,
   output upd_entry_t pop_data,
   output logic       full,
   output logic       empty
);

   localparam int PW = $clog2(DEPTH);

   upd_entry_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/bht_controller.sv
// Branch history table controller: initialises 2^IDX_BITS two-bit counters,
// answers one lookup per cycle with one cycle latency, and applies resolved
// updates through a small FIFO, one read-modify-write per cycle.
// Optional: define BHT_GSHARE_EN to XOR a global history register into the index.
module bht_controller
   import bht_pkg::*;
#(
   parameter int   IDX_BITS   = BHT_IDX_BITS,
   parameter int   UPD_DEPTH  = 4,
   parameter ctr_t INIT_STATE = WEAK_NT,
   parameter int   HIST_BITS  = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   output logic        pred_resp_valid,
   output logic        pred_taken,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   output logic        init_done
);

   localparam int ENTRIES = 1 << IDX_BITS;

   state_t              state_q;
   state_t              state_d;
   logic [IDX_BITS-1:0] init_idx_q;
   logic [IDX_BITS-1:0] pred_idx;
   logic [IDX_BITS-1:0] upd_idx;
   ctr_t                tbl [ENTRIES];
   upd_entry_t          push_data;
   upd_entry_t          head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                run;
   logic                push;
   logic                pop;
   logic                resp_vld_q;
   logic                resp_taken_q;

   assign run = (state_q == RUN);

`ifdef BHT_GSHARE_EN
   logic [HIST_BITS-1:0] ghr_q;

   assign pred_idx = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
   assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);

   // Global history shifts in each accepted outcome; INIT never pushes, so it holds there.
   always_ff @(posedge clk) begin
      if (!rst)      ghr_q <= '0;
      else if (push) ghr_q <= {ghr_q[HIST_BITS-2:0], upd_taken};
   end
`else
   assign pred_idx = pred_pc[IDX_BITS+1:2];
   assign upd_idx  = upd_pc[IDX_BITS+1:2];
`endif

   // FSM state and init sweep index; reset restarts the sweep from entry 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= INIT;
         init_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT) init_idx_q <= init_idx_q + 1'b1;
      end
   end

   // Leave INIT right after the last entry is written; RUN is left only by reset.
   always_comb begin
      state_d = state_q;
      if (state_q == INIT && init_idx_q == IDX_BITS'(ENTRIES-1)) state_d = RUN;
   end

   // Full blocks acceptance even if a drain frees a slot this cycle.
   assign upd_ready = rst && run && !fifo_full;
   assign push      = upd_valid && upd_ready;
   assign pop       = run && !fifo_empty;
   assign push_data = '{idx: upd_idx, taken: upd_taken};

   bht_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Single table write port: init sweep in INIT, otherwise the FIFO head's read-modify-write.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (!run)     tbl[init_idx_q] <= INIT_STATE;
         else if (pop) tbl[head.idx]   <= sat_next(tbl[head.idx], head.taken);
      end
   end

   // Lookup reads the pre-write table, so a same-cycle drain is not bypassed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         resp_vld_q   <= 1'b0;
         resp_taken_q <= 1'b0;
      end else begin
         resp_vld_q   <= run && pred_valid;
         resp_taken_q <= run && pred_valid && tbl[pred_idx][1];
      end
   end

   assign pred_resp_valid = resp_vld_q;
   assign pred_taken      = resp_taken_q;
   assign init_done       = run;

endmodule
